// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int NCOLS   = 4;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Multiply by x (0x02) in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x03 in GF(2^8).
  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // ShiftRows: out(r,c) = in(r,(c+r) mod 4); byte i lives in b[15-i].
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[15], b[10], b[5],  b[0],
            b[11], b[6],  b[1],  b[12],
            b[7],  b[2],  b[13], b[8],
            b[3],  b[14], b[9],  b[4]};
  endfunction

endpackage

// File: rtl/aes_shiftmix_seq_if.sv
// Handshake bus of aes_shiftmix_seq: input state/key channel and result channel.
interface aes_shiftmix_seq_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic [STATE_W-1:0] round_key;
  logic               last_round;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state, round_key, last_round, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, round_key, last_round, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/aes_mixcol_col.sv
// Combinational MixColumns over a single 32-bit column (row0 byte in [31:24]).
module aes_mixcol_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             bypass,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_in;

  // Matrix rows 02 03 01 01 rotated; final round passes the column through
  always_comb begin
    if (bypass) begin
      col_out = col_in;
    end else begin
      col_out = {xtime(a0) ^ mul3(a1)  ^ a2        ^ a3,
                 a0        ^ xtime(a1) ^ mul3(a2)  ^ a3,
                 a0        ^ a1        ^ xtime(a2) ^ mul3(a3),
                 mul3(a0)  ^ a1        ^ a2        ^ xtime(a3)};
    end
  end

endmodule

// File: rtl/aes_shiftmix_seq.sv
// AES round tail: ShiftRows on capture, then MixColumns (+ AddRoundKey when
// AES_SHIFTMIX_KEYADD_EN is defined) over COLS_PER_CYCLE columns per cycle.
module aes_shiftmix_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  aes_shiftmix_seq_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("aes_shiftmix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step of 4 wraps to 0 in the 2-bit counter, which is exactly what we want.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(NCOLS - COLS_PER_CYCLE);

  fsm_t               state, state_nxt;
  logic               armed;
  logic               hs;
  logic               busy;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] st_p1;
  logic               last_p1;
  logic [STATE_W-1:0] st_nxt;
  logic [COL_W-1:0]   cols     [NCOLS];
  logic [COL_W-1:0]   cols_nxt [NCOLS];
  logic [1:0]         col_idx  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   mix_in   [COLS_PER_CYCLE];
  logic [COL_W-1:0]   mix_out  [COLS_PER_CYCLE];

  for (genvar k = 0; k < NCOLS; k++) begin : g_cols
    assign cols[k] = st_p1[STATE_W-1-COL_W*k -: COL_W];
    assign st_nxt[STATE_W-1-COL_W*k -: COL_W] = cols_nxt[k];
  end

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_mix
    assign col_idx[i] = cnt + 2'(i);
    assign mix_in[i]  = cols[col_idx[i]];
    aes_mixcol_col u_col (
      .col_in  (mix_in[i]),
      .bypass  (last_p1),
      .col_out (mix_out[i])
    );
  end

`ifdef AES_SHIFTMIX_KEYADD_EN
  logic [STATE_W-1:0] key_p1;
  logic [COL_W-1:0]   key_cols [NCOLS];

  for (genvar k = 0; k < NCOLS; k++) begin : g_key
    assign key_cols[k] = key_p1[STATE_W-1-COL_W*k -: COL_W];
  end

  // Round key is only consumed after a handshake, so it needs no reset
  always_ff @(posedge clk) begin
    if (hs) key_p1 <= bus.round_key;
  end
`else
  logic unused_round_key;
  assign unused_round_key = ^bus.round_key;
`endif

  // Transformed columns are written back in place; the others hold
  always_comb begin
    for (int k = 0; k < NCOLS; k++) cols_nxt[k] = cols[k];
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
`ifdef AES_SHIFTMIX_KEYADD_EN
      cols_nxt[col_idx[i]] = mix_out[i] ^ key_cols[col_idx[i]];
`else
      cols_nxt[col_idx[i]] = mix_out[i];
`endif
    end
  end

  // FSM state register; armed keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; in_ready depends on registered state only
  always_comb begin
    bus.in_ready  = (state == IDLE) && armed;
    bus.out_valid = (state == DONE);
    busy          = (state == BUSY);
  end

  assign hs            = bus.in_valid && bus.in_ready;
  assign bus.out_state = st_p1;

  // Datapath: capture ShiftRows(in_state) on handshake, then transform in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_p1   <= '0;
      last_p1 <= 1'b0;
      cnt     <= 2'd0;
    end else if (hs) begin
      st_p1   <= shift_rows(bus.in_state);
      last_p1 <= bus.last_round;
      cnt     <= 2'd0;
    end else if (busy) begin
      st_p1   <= st_nxt;
      cnt     <= cnt + CNT_STEP;
    end
  end

endmodule

// File: tb/tb_aes_shiftmix_seq.sv
// Scoreboard bench for aes_shiftmix_seq: three instances (1, 2 and 4 columns
// per cycle) are fed identical transactions and checked against a byte-matrix
// reference model. Honours AES_SHIFTMIX_KEYADD_EN like the design.
module tb_aes_shiftmix_seq;

  typedef struct {
    logic [127:0] st;
    int           issue;
  } exp_t;

  localparam logic [127:0] V1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`ifdef AES_SHIFTMIX_KEYADD_EN
  localparam logic [127:0] V1_EXP = 128'ha49c7ff2689f352b6b5bea43026a5049;
`else
  localparam logic [127:0] V1_EXP = 128'h046681e5e0cb199a48f8d37a2806264c;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   ordy_mode = 0;
  logic pv [3] = '{1'b0, 1'b0, 1'b0};
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_shiftmix_seq_if if0 ();
  aes_shiftmix_seq_if if1 ();
  aes_shiftmix_seq_if if2 ();

  aes_shiftmix_seq #(.COLS_PER_CYCLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  aes_shiftmix_seq #(.COLS_PER_CYCLE(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  aes_shiftmix_seq #(.COLS_PER_CYCLE(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k,
                                             input logic lr);
    logic [7:0]   a [4][4];
    logic [7:0]   b [4][4];
    logic [7:0]   o;
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) a[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r][c] = a[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (lr) o = b[r][c];
        else o = gmul(8'd2, b[r][c]) ^ gmul(8'd3, b[(r+1)%4][c]) ^ b[(r+2)%4][c] ^ b[(r+3)%4][c];
`ifdef AES_SHIFTMIX_KEYADD_EN
        o = o ^ k[127-8*(4*c+r) -: 8];
`endif
        res[127-8*(4*c+r) -: 8] = o;
      end
    return res;
  endfunction

  function automatic int lat_of(input int ln);
    return (ln == 0) ? 4 : (ln == 1) ? 2 : 1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: latency on each rising out_valid, data on each output handshake.
  task automatic mon(input int ln, input logic ov, input logic ordy, input logic [127:0] os);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (ln)
      0: if (q0.size() > 0) begin e = q0[0]; have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1[0]; have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2[0]; have = 1'b1; end
    endcase
    if (ov && !pv[ln]) begin
      if (!have) chk($sformatf("lane%0d_spurious_valid", ln), 1, 0);
      else chk($sformatf("lane%0d_latency", ln), cyc - e.issue - 1, lat_of(ln));
    end
    if (ov && ordy && have) begin
      chk($sformatf("lane%0d_out_state", ln), os, e.st);
      case (ln)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
    pv[ln] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, if0.out_valid, if0.out_ready, if0.out_state);
    mon(1, if1.out_valid, if1.out_ready, if1.out_state);
    mon(2, if2.out_valid, if2.out_ready, if2.out_state);
  end

  // Downstream ready: random, forced low, or forced high.
  always @(posedge clk) begin
    logic r;
    #1;
    case (ordy_mode)
      0:       r = ($urandom_range(0, 3) != 0);
      1:       r = 1'b0;
      default: r = 1'b1;
    endcase
    if0.out_ready = r;
    if1.out_ready = r;
    if2.out_ready = r;
  end

  task automatic drive_in(input logic v, input logic [127:0] s, input logic [127:0] k,
                          input logic lr);
    if0.in_valid = v; if0.in_state = s; if0.round_key = k; if0.last_round = lr;
    if1.in_valid = v; if1.in_state = s; if1.round_key = k; if1.last_round = lr;
    if2.in_valid = v; if2.in_state = s; if2.round_key = k; if2.last_round = lr;
  endtask

  // Called 2 time units after a rising edge; returns at the same phase.
  task automatic issue(input logic [127:0] s, input logic [127:0] k, input logic lr,
                       input logic [127:0] exp);
    exp_t e;
    int   b;
    b = 0;
    while (!(if0.in_ready && if1.in_ready && if2.in_ready) && b < 200) begin
      @(posedge clk); #2;
      b++;
    end
    chk("issue_ready_wait", (b < 200), 1);
    drive_in(1'b1, s, k, lr);
    e.st    = exp;
    e.issue = cyc;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    @(posedge clk); #2;
    drive_in(1'b0, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && b < 400) begin
      @(posedge clk); #2;
      b++;
    end
    chk("drain_wait", (b < 400), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, k, e;
    logic [127:0] snap0, snap1, snap2;
    logic         lr;
    int           b;

    drive_in(1'b0, '0, '0, 1'b0);
    if0.out_ready = 1'b0; if1.out_ready = 1'b0; if2.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", {if0.out_valid, if1.out_valid, if2.out_valid}, 3'b000);
    chk("rst_out_state", if0.out_state | if1.out_state | if2.out_state, 0);
    chk("rst_in_ready", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b111);
    #1;

    // Known FIPS-197 vectors
    issue(V1_IN, V1_KEY, 1'b0, V1_EXP);
    issue(V1_IN, '0, 1'b1, V_SR);
    for (int i = 0; i < 3; i++) begin
      k = rnd128();
`ifdef AES_SHIFTMIX_KEYADD_EN
      e = ref_model(V1_IN, k, 1'b0);
`else
      e = V1_EXP;
`endif
      issue(V1_IN, k, 1'b0, e);
    end

    // Random traffic with random downstream back-pressure
    for (int i = 0; i < 40; i++) begin
      s  = rnd128();
      k  = rnd128();
      lr = ($urandom_range(0, 3) == 0);
      issue(s, k, lr, ref_model(s, k, lr));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    wait_drain();

    // Output stall: result must hold and new requests must be ignored
    ordy_mode = 1;
    @(posedge clk); #2;
    issue(V1_IN, V1_KEY, 1'b0, V1_EXP);
    b = 0;
    while (!(if0.out_valid && if1.out_valid && if2.out_valid) && b < 50) begin
      @(posedge clk); #2;
      b++;
    end
    chk("stall_reach_done", {if0.out_valid, if1.out_valid, if2.out_valid}, 3'b111);
    snap0 = if0.out_state; snap1 = if1.out_state; snap2 = if2.out_state;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      drive_in(1'b1, rnd128(), rnd128(), 1'($urandom_range(0, 1)));
      #1;
      chk("stall_out_valid", {if0.out_valid, if1.out_valid, if2.out_valid}, 3'b111);
      chk("stall_in_ready", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b000);
      chk("stall_state_c1", if0.out_state, snap0);
      chk("stall_state_c2", if1.out_state, snap1);
      chk("stall_state_c4", if2.out_state, snap2);
    end
    drive_in(1'b0, '0, '0, 1'b0);
    ordy_mode = 2;
    @(posedge clk); #2;
    wait_drain();
    ordy_mode = 0;

    // Reset while the 1-column instance is busy at counter 2
    issue(V1_IN, V1_KEY, 1'b0, V1_EXP);
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {if0.out_valid, if1.out_valid, if2.out_valid}, 3'b000);
    chk("midrst_out_state", if0.out_state | if1.out_state | if2.out_state, 0);
    chk("midrst_in_ready", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b000);
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk); #2;
    chk("midrst_in_ready_held", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_release", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b111);
    #1;
    issue(V1_IN, V1_KEY, 1'b0, V1_EXP);
    s = rnd128();
    k = rnd128();
    issue(s, k, 1'b0, ref_model(s, k, 1'b0));
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_shiftmix_seq.md
AES_SHIFTMIX_SEQ -- requirements
Module: aes_shiftmix_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning the number of state columns processed per cycle; legal values 1, 2, 4, others rejected at elaboration.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  input state/key offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an input.
REQ-006 SHALL have port in_state  input  128  AES state after SubBytes, column-major, byte0 = [127:120] (row0,col0), byte1 = row1,col0, ...
REQ-007 SHALL have port round_key  input  128  round key, same byte order.
REQ-008 SHALL have port last_round  input  1  final round: MixColumns bypassed.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_state  output  128  result state, same byte order.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE; handshake = in_valid && in_ready.
REQ-014 SHALL, on handshake, register ShiftRows(in_state), round_key and last_round, clear the column counter and enter BUSY. ShiftRows: out(r,c) = in(r,(c+r) mod 4).
REQ-015 SHALL, each BUSY cycle, transform COLS_PER_CYCLE columns in place starting at the counter: MixColumns (GF(2^8), poly 0x11B, matrix rows 02 03 01 01 rotated) unless last_round, then XOR with the matching round_key column.
REQ-016 SHALL advance the counter by COLS_PER_CYCLE modulo 4 and enter DONE after the cycle that processes column 3; latency handshake-to-out_valid = 4/COLS_PER_CYCLE cycles.
REQ-017 SHALL assert out_valid only in DONE and hold out_state stable until out_valid && out_ready, then return to IDLE.
REQ-018 SHALL ignore in_valid, in_state, round_key and last_round outside the handshake cycle.
REQ-019 SHALL give in_ready no combinational path from out_ready; back-to-back issue costs one IDLE cycle.

Reset
REQ-020 SHALL, on rst_n low, immediately force IDLE, counter 0, out_valid 0, in_ready 0 while low, out_state 128'h0, with any in-flight operation discarded.
REQ-021 SHALL assert in_ready on the first rising clk edge after rst_n deasserts.

Configuration
REQ-022 SHALL, with AES_SHIFTMIX_KEYADD_EN defined, perform AddRoundKey per REQ-015.
REQ-023 SHALL, without AES_SHIFTMIX_KEYADD_EN, omit the key register and XOR: round_key is unused and out_state = MixColumns(ShiftRows) or ShiftRows alone when last_round.

Structure
REQ-024 SHALL take the state width (128), column count (4), the FSM state encoding and the xtime/GF multiply function from a shared package, aes_pkg.
REQ-025 SHALL instantiate one sub-module, aes_mixcol_col, that is combinational over one 32-bit column, replicated COLS_PER_CYCLE times.

Verification
REQ-026 SHALL check the FIPS-197 App.B round 1: in_state d42711aee0bf9\u200b8f1b8b45de51e415230, key a0fafe1788542cb123a339392a6c7605, last_round=0 -> out_state a49c7ff2689f352b6b5bea43026a5049 after 4 cycles (COLS_PER_CYCLE=1).
REQ-027 SHALL check the same vector with last_round=1 and key 0 -> out_state d4bf5d30e0b452aeb84111f11e2798e5 (pure ShiftRows).
REQ-028 SHALL check the same vector at COLS_PER_CYCLE=2 and at COLS_PER_CYCLE=4 -> identical result, out_valid after 2 and after 1 cycles.
REQ-029 SHALL check out_ready held low for 10 cycles -> out_valid and out_state stable, in_ready 0, and a new in_valid ignored.
REQ-030 SHALL check rst_n pulsed low in BUSY at counter 2 -> out_valid 0 and out_state 0 at once, in_ready 1 one edge after release, with the next vector correct.
REQ-031 SHALL check without AES_SHIFTMIX_KEYADD_EN -> vector 1 gives 046681e5e0cb199a48f8d37a2806264c and round_key toggling has no effect.
